// File: rtl/pmu_seq_pkg.sv
// Shared types for the power-rail sequencer: FSM states, fault causes and
// a lowest-set-bit helper used to name the offending rail.
package pmu_seq_pkg;

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MAX_NCH = 8;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4,
    ST_FAULT  = 3'd5
  } pmu_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_TIMEOUT  = 2'd1,
    FC_BROWNOUT = 2'd2
  } fault_code_e;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_NCH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(MAX_NCH) - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pmu_seq_cnt.sv
// Clearable up-counter shared by the rdy timeout and the settle hold,
// with a combinational compare against the active terminal value.
module pmu_seq_cnt #(
  parameter int unsigned TW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [TW-1:0] i_term,
  output logic          o_hit_c
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_hit_c = (r_cnt == i_term);

endmodule

// File: rtl/pmu_seq_ctrl.sv
// Power-rail sequencer: enables rails in order, waits for each ready plus a
// settle hold, watches for brown-out, and unwinds rails in reverse on power-down.
module pmu_seq_ctrl
  import pmu_seq_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned TW  = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_pwr_up_req,
  input  logic [NCH-1:0] i_rdy,
  input  logic [NCH-1:0] i_vlo,
  input  logic [TW-1:0]  i_cfg_timeout,
  input  logic [TW-1:0]  i_cfg_settle,
  input  logic           i_fault_clr,
  output logic [NCH-1:0] o_ena,
  output logic           o_pwr_good,
  output logic           o_por,
  output logic           o_fault,
  output logic [2:0]     o_fault_ch,
  output logic [1:0]     o_fault_code,
  output logic [2:0]     o_state
);

  pmu_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [NCH-1:0]   r_ena;
  logic             r_pwr_good;
  logic             r_por;
  logic             r_fault;
  logic [IDX_W-1:0] r_fault_ch;
  fault_code_e      r_fault_code;

  logic [NCH-1:0]   w_idx_oh;
  logic [NCH-1:0]   w_settled;
  logic [NCH-1:0]   w_bo_mask;
  logic             w_rdy_cur;
  logic             w_last;
  logic             w_hit;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic [TW-1:0]    w_term;
  logic             w_fault_go;
  fault_code_e      w_fault_cause;
  logic [IDX_W-1:0] w_fault_idx;

  assign w_idx_oh  = NCH'(1) << r_idx;
  assign w_rdy_cur = |(i_rdy & w_idx_oh);
  assign w_last    = (r_idx == IDX_W'(NCH - 1));
  assign w_term    = (r_state == ST_RAMP) ? i_cfg_timeout : i_cfg_settle;

  // Rails below the current index have already completed their settle hold.
  always_comb begin
    w_settled = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_settled[i] = (IDX_W'(i) < r_idx);
    end
  end

  // Brown-out candidates: ON watches every rail, sequencing only live ones.
  always_comb begin
    w_bo_mask = '0;
    if (r_state == ST_ON) begin
      w_bo_mask = i_vlo | ~i_rdy;
    end else if (r_state == ST_RAMP || r_state == ST_SETTLE) begin
      w_bo_mask = (i_vlo & r_ena) | (~i_rdy & w_settled);
    end
  end

  always_comb begin
    w_fault_go    = 1'b0;
    w_fault_cause = FC_NONE;
    w_fault_idx   = '0;
    if (|w_bo_mask) begin
      w_fault_go    = 1'b1;
      w_fault_cause = FC_BROWNOUT;
      w_fault_idx   = lowest_set(MAX_NCH'(w_bo_mask));
    end else if (r_state == ST_RAMP && !w_rdy_cur && w_hit) begin
      w_fault_go    = 1'b1;
      w_fault_cause = FC_TIMEOUT;
      w_fault_idx   = r_idx;
    end
  end

  // The counter runs only while the FSM stays put; any transition restarts it.
  always_comb begin
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_RAMP:   w_cnt_inc = !w_fault_go && i_pwr_up_req && !w_rdy_cur;
      ST_SETTLE: w_cnt_inc = !w_fault_go && i_pwr_up_req && !w_hit;
      ST_DOWN:   w_cnt_inc = !w_hit;
      default:   w_cnt_inc = 1'b0;
    endcase
    w_cnt_clr = !w_cnt_inc;
  end

  pmu_seq_cnt #(
    .TW (TW)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .i_term  (w_term),
    .o_hit_c (w_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_OFF;
      r_idx        <= '0;
      r_ena        <= '0;
      r_pwr_good   <= 1'b0;
      r_por        <= 1'b1;
      r_fault      <= 1'b0;
      r_fault_ch   <= '0;
      r_fault_code <= FC_NONE;
    end else if (w_fault_go) begin
      r_state      <= ST_FAULT;
      r_ena        <= '0;
      r_pwr_good   <= 1'b0;
      r_por        <= 1'b1;
      r_fault      <= 1'b1;
      r_fault_ch   <= w_fault_idx;
      r_fault_code <= w_fault_cause;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (i_pwr_up_req) begin
            r_state <= ST_RAMP;
            r_idx   <= '0;
            r_ena   <= NCH'(1);
          end
        end
        ST_RAMP: begin
          if (!i_pwr_up_req) begin
            r_state    <= ST_DOWN;
            r_ena      <= r_ena & ~w_idx_oh;
            r_pwr_good <= 1'b0;
            r_por      <= 1'b1;
          end else if (w_rdy_cur) begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!i_pwr_up_req) begin
            r_state    <= ST_DOWN;
            r_ena      <= r_ena & ~w_idx_oh;
            r_pwr_good <= 1'b0;
            r_por      <= 1'b1;
          end else if (w_hit) begin
            if (w_last) begin
              r_state    <= ST_ON;
              r_pwr_good <= 1'b1;
              r_por      <= 1'b0;
            end else begin
              r_state <= ST_RAMP;
              r_idx   <= r_idx + IDX_W'(1);
              r_ena   <= r_ena | (w_idx_oh << 1);
            end
          end
        end
        ST_ON: begin
          if (!i_pwr_up_req) begin
            r_state    <= ST_DOWN;
            r_ena      <= r_ena & ~w_idx_oh;
            r_pwr_good <= 1'b0;
            r_por      <= 1'b1;
          end
        end
        // Request changes are ignored here until the last rail has been released.
        ST_DOWN: begin
          if (w_hit) begin
            if (r_idx == '0) begin
              r_state <= ST_OFF;
            end else begin
              r_idx <= r_idx - IDX_W'(1);
              r_ena <= r_ena & ~(w_idx_oh >> 1);
            end
          end
        end
        ST_FAULT: begin
          if (i_fault_clr && !i_pwr_up_req) begin
            r_state      <= ST_OFF;
            r_idx        <= '0;
            r_fault      <= 1'b0;
            r_fault_ch   <= '0;
            r_fault_code <= FC_NONE;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_ena   <= '0;
        end
      endcase
    end
  end

  assign o_ena        = r_ena;
  assign o_pwr_good   = r_pwr_good;
  assign o_por        = r_por;
  assign o_fault      = r_fault;
  assign o_fault_ch   = r_fault_ch;
  assign o_fault_code = r_fault_code;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pmu_seq_ctrl.sv
// Bench for pmu_seq_ctrl: randomized rail-ready delays and fault injections
// checked against an event-schedule model of the sequencing rules.
`timescale 1ns/1ps
module tb_pmu_seq_ctrl;
  import pmu_seq_pkg::*;

  localparam int NCH = 4;
  localparam int BIG = 1 << 30;

  logic             clk = 1'b0;
  logic             reset, req, fclr;
  logic [NCH-1:0]   rdy, vlo, ena;
  logic [15:0]      tmo, stl;
  logic             pg, por, fault;
  logic [2:0]       fch, st;
  logic [1:0]       fcode;

  logic             req1;
  logic [0:0]       rdy1, vlo1, ena1;
  logic             pg1, por1, fault1;
  logic [2:0]       fch1, st1;
  logic [1:0]       fcode1;

  int total = 0;
  int bad   = 0;
  int S, T;
  int dly   [NCH];
  int t_ena [NCH];
  int t_on, t_flt;

  always #5 clk = ~clk;

  pmu_seq_ctrl #(.NCH(NCH), .TW(16)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_pwr_up_req(req), .i_rdy(rdy), .i_vlo(vlo),
    .i_cfg_timeout(tmo), .i_cfg_settle(stl), .i_fault_clr(fclr),
    .o_ena(ena), .o_pwr_good(pg), .o_por(por), .o_fault(fault),
    .o_fault_ch(fch), .o_fault_code(fcode), .o_state(st));

  pmu_seq_ctrl #(.NCH(1), .TW(16)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_pwr_up_req(req1), .i_rdy(rdy1), .i_vlo(vlo1),
    .i_cfg_timeout(tmo), .i_cfg_settle(stl), .i_fault_clr(fclr),
    .o_ena(ena1), .o_pwr_good(pg1), .o_por(por1), .o_fault(fault1),
    .o_fault_ch(fch1), .o_fault_code(fcode1), .o_state(st1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [NCH-1:0] m);
    int r;
    r = -1;
    for (int i = 0; i < NCH; i++) if (r < 0 && m[i]) r = i;
    return r;
  endfunction

  // Schedule of a power-up relative to raising the request at cycle 0:
  // rail i enables at t_ena[i], answers dly[i] cycles later, settles S+1 cycles.
  task automatic plan(input int fail);
    int t;
    bit done;
    t = 1;
    done = 0;
    t_on = BIG;
    t_flt = BIG;
    for (int i = 0; i < NCH; i++) begin
      t_ena[i] = BIG;
      if (!done) begin
        t_ena[i] = t;
        if (i == fail) begin
          t_flt = t + T + 1;
          done = 1;
        end else begin
          t = t + dly[i] + S + 2;
        end
      end
    end
    if (fail < 0) t_on = t;
  endtask

  task automatic power_up(input int fail, input int stop_c);
    int t_end;
    logic [NCH-1:0] e;
    t_end = (fail < 0) ? t_on : t_flt;
    if (stop_c < t_end) t_end = stop_c;
    req = 1'b1;
    rdy = '0;
    vlo = '0;
    for (int c = 1; c <= t_end; c++) begin
      tick();
      e = '0;
      for (int i = 0; i < NCH; i++) if (c >= t_ena[i] && c < t_flt) e[i] = 1'b1;
      chk("up_ena", 32'(ena), 32'(e));
      chk("up_pwr_good", 32'(pg), 32'(c >= t_on));
      chk("up_por", 32'(por), 32'(c < t_on));
      chk("up_fault", 32'(fault), 32'(c >= t_flt));
      if (c == t_on) chk("up_state_on", 32'(st), 32'(ST_ON));
      if (c == t_flt) begin
        chk("tmo_code", 32'(fcode), 32'(FC_TIMEOUT));
        chk("tmo_ch", 32'(fch), 32'(fail));
        chk("tmo_state", 32'(st), 32'(ST_FAULT));
      end
      for (int i = 0; i < NCH; i++) if (i != fail && c >= t_ena[i] + dly[i]) rdy[i] = 1'b1;
    end
  endtask

  task automatic clear_fault();
    rdy = '0;
    vlo = '0;
    fclr = 1'b1;
    req = 1'b1;
    tick();
    fclr = 1'b0;
    chk("clr_ignored_fault", 32'(fault), 32'd1);
    chk("clr_ignored_state", 32'(st), 32'(ST_FAULT));
    tick();
    chk("clr_hold_fault", 32'(fault), 32'd1);
    fclr = 1'b1;
    req = 1'b0;
    tick();
    fclr = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fcode), 32'(FC_NONE));
    chk("clr_ch", 32'(fch), 32'd0);
    chk("clr_ena", 32'(ena), 32'd0);
    chk("clr_state", 32'(st), 32'(ST_OFF));
  endtask

  // From ON: inject undervoltage / ready-drop masks for one cycle.
  task automatic brownout_on(input logic [NCH-1:0] vm, input logic [NCH-1:0] dm, input bit drop);
    vlo = vm;
    rdy = ~dm;
    req = !drop;
    tick();
    chk("bo_fault", 32'(fault), 32'd1);
    chk("bo_code", 32'(fcode), 32'(FC_BROWNOUT));
    chk("bo_ch", 32'(fch), 32'(lowest(vm | dm)));
    chk("bo_ena", 32'(ena), 32'd0);
    chk("bo_pwr_good", 32'(pg), 32'd0);
    chk("bo_por", 32'(por), 32'd1);
    chk("bo_state", 32'(st), 32'(ST_FAULT));
    clear_fault();
  endtask

  // From ON: rails release top-down every S+1 cycles; OFF follows rail 0's hold.
  task automatic power_down(input bit noise, input bit back);
    int t_off;
    logic [NCH-1:0] e;
    t_off = 1 + NCH * (S + 1);
    req = 1'b0;
    for (int c = 1; c <= t_off + 1; c++) begin
      tick();
      e = '0;
      for (int i = 0; i < NCH; i++) if (c < 1 + (NCH - 1 - i) * (S + 1)) e[i] = 1'b1;
      if (back && c == t_off + 1) e = NCH'(1);
      chk("dn_ena", 32'(ena), 32'(e));
      chk("dn_pwr_good", 32'(pg), 32'd0);
      chk("dn_por", 32'(por), 32'd1);
      chk("dn_fault", 32'(fault), 32'd0);
      if (c == t_off) chk("dn_state_off", 32'(st), 32'(ST_OFF));
      if (noise && c < t_off) begin
        vlo = NCH'($urandom);
        rdy = NCH'($urandom);
      end else begin
        vlo = '0;
        rdy = '0;
      end
      if (back && c >= 2) req = 1'b1;
    end
    if (back) begin
      req = 1'b0;
      repeat (S + 2) tick();
      chk("dn_back_ena", 32'(ena), 32'd0);
      chk("dn_back_state", 32'(st), 32'(ST_OFF));
    end
  endtask

  task automatic rand_dly();
    for (int i = 0; i < NCH; i++) dly[i] = int'($urandom_range(T, 0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ena"}, 32'(ena), 32'd0);
    chk({tag, "_pwr_good"}, 32'(pg), 32'd0);
    chk({tag, "_por"}, 32'(por), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_ch"}, 32'(fch), 32'd0);
    chk({tag, "_code"}, 32'(fcode), 32'd0);
    chk({tag, "_state"}, 32'(st), 32'(ST_OFF));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NCH-1:0] vm, dm;
    logic [1:0] vm2;
    bit drop0;
    S = 3;
    T = 10;
    stl = 16'(S);
    tmo = 16'(T);
    reset = 1'b1;
    req = 1'b0;
    rdy = '0;
    vlo = '0;
    fclr = 1'b0;
    req1 = 1'b0;
    rdy1 = '0;
    vlo1 = '0;
    tick();
    tick();
    chk_reset("rst");
    chk("rst1_ena", 32'(ena1), 32'd0);
    chk("rst1_por", 32'(por1), 32'd1);
    reset = 1'b0;
    tick();

    // Nominal power-up, every rail answering 2 cycles after its enable
    for (int i = 0; i < NCH; i++) dly[i] = 2;
    plan(-1);
    power_up(-1, BIG);
    power_down(1'b1, 1'b0);

    // Randomized power-ups followed by different exits
    for (int it = 0; it < 4; it++) begin
      rand_dly();
      if (it == 0) dly[NCH-1] = T;
      plan(-1);
      power_up(-1, BIG);
      case (it)
        0: brownout_on(4'b1010, 4'b0000, 1'b0);
        1: begin
          vm = NCH'($urandom);
          dm = NCH'($urandom);
          if ((vm | dm) == '0) vm = 4'b0100;
          brownout_on(vm, dm, 1'b1);
        end
        2: power_down(1'b0, 1'b1);
        default: power_down(1'b1, 1'b0);
      endcase
    end

    // Rail 2 never answers: timeout fault
    rand_dly();
    plan(2);
    power_up(2, BIG);
    clear_fault();

    // Brown-out while ramping rail 1
    rand_dly();
    dly[1] = T;
    plan(-1);
    power_up(-1, t_ena[1] + 1);
    vlo = 4'b1000;
    tick();
    chk("ramp_vlo_off_rail", 32'(fault), 32'd0);
    chk("ramp_ena", 32'(ena), 32'd3);
    vm2 = 2'($urandom);
    drop0 = 1'($urandom);
    if (vm2 == 2'b00 && !drop0) vm2 = 2'b10;
    vlo = {2'b00, vm2};
    rdy[0] = !drop0;
    tick();
    chk("ramp_bo_fault", 32'(fault), 32'd1);
    chk("ramp_bo_code", 32'(fcode), 32'(FC_BROWNOUT));
    chk("ramp_bo_ch", 32'(fch), 32'(lowest({2'b00, vm2} | {3'b000, drop0})));
    chk("ramp_bo_ena", 32'(ena), 32'd0);
    clear_fault();

    // Reset while ramping rail 1, then a fresh power-up from rail 0
    rand_dly();
    dly[1] = T;
    plan(-1);
    power_up(-1, t_ena[1] + 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rdy = '0;
    chk_reset("midrst");
    rand_dly();
    plan(-1);
    power_up(-1, BIG);
    power_down(1'b0, 1'b0);

    // Zero timeout: rdy low faults at once, rdy already high still settles
    T = 0;
    tmo = 16'(T);
    plan(0);
    power_up(0, BIG);
    clear_fault();
    for (int i = 0; i < NCH; i++) dly[i] = 0;
    plan(-1);
    power_up(-1, BIG);
    power_down(1'b0, 1'b0);
    T = 10;
    tmo = 16'(T);

    // Single-rail build: up, down with undervoltage noise, request held in DOWN
    req1 = 1'b1;
    for (int c = 1; c <= S + 3; c++) begin
      tick();
      chk("n1_up_ena", 32'(ena1), 32'd1);
      chk("n1_up_pwr_good", 32'(pg1), 32'(c >= S + 3));
      rdy1 = 1'b1;
    end
    req1 = 1'b0;
    for (int c = 1; c <= S + 3; c++) begin
      tick();
      chk("n1_dn_ena", 32'(ena1), 32'(c >= S + 3));
      chk("n1_dn_pwr_good", 32'(pg1), 32'd0);
      chk("n1_dn_fault", 32'(fault1), 32'd0);
      rdy1 = 1'b0;
      vlo1 = 1'(c < S + 2);
      if (c >= 2) req1 = 1'b1;
    end
    req1 = 1'b0;
    repeat (S + 3) tick();
    chk("n1_end_ena", 32'(ena1), 32'd0);
    chk("n1_end_fault", 32'(fault1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmu_seq_ctrl.md
PMU_SEQ_CTRL -- requirements
Module: pmu_seq_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of sequenced regulator rails, legal range 1..8.
REQ-002 Parameter TW, default 16, width of timeout/settle counters and config fields.
REQ-003 clk  input  1  single block clock.
REQ-004 reset  input  1  synchronous, active-high; the only reset of the block.
REQ-005 pwr_up_req  input  1  level request: 1 = power rails up, 0 = power down.
REQ-006 rdy  input  NCH  per-rail regulator ready flag, already synchronised to clk.
REQ-007 vlo  input  NCH  per-rail undervoltage comparator flag, already synchronised to clk.
REQ-008 cfg_timeout  input  TW  maximum cycles to wait for rdy of the current rail.
REQ-009 cfg_settle  input  TW  hold cycles after each rail ready and after each rail disable.
REQ-010 fault_clr  input  1  single-cycle pulse that clears a latched fault.
REQ-011 ena  output  NCH  regulator enables, bit i drives rail i.
REQ-012 pwr_good  output  1  high only in state ON.
REQ-013 por  output  1  downstream domain reset, active-high, low only in state ON.
REQ-014 fault  output  1  latched fault flag.
REQ-015 fault_ch  output  3  rail index that caused the fault.
REQ-016 fault_code  output  2  fault cause: 0 none, 1 rdy timeout, 2 brown-out.
REQ-017 state  output  3  current FSM state encoding, for debug.

Function
REQ-018 The FSM SHALL have states OFF, RAMP, SETTLE, ON, DOWN and FAULT; a rail index idx SHALL select the current rail.
REQ-019 In OFF with pwr_up_req=1, the FSM SHALL set idx=0, set ena[0], clear the counter and go to RAMP on the next cycle.
REQ-020 In RAMP, the counter SHALL increment on each cycle with rdy[idx]=0; rdy[idx]=1 SHALL clear the counter and move to SETTLE.
REQ-021 In RAMP, rdy[idx]=0 with counter==cfg_timeout SHALL move to FAULT with fault_code=1 and fault_ch=idx; cfg_timeout=0 therefore faults on the first RAMP cycle if rdy is low.
REQ-022 SETTLE SHALL last cfg_settle+1 cycles; it SHALL then go to ON if idx==NCH-1, else increment idx, set ena[idx] and return to RAMP.
REQ-023 In RAMP or SETTLE, rdy of any already-settled rail dropping, or vlo of any enabled rail rising, SHALL move to FAULT with fault_code=2 and fault_ch set to the lowest offending index.
REQ-024 In ON, any vlo[i]=1 or rdy[i]=0 SHALL move to FAULT with fault_code=2 and fault_ch set to the lowest offending index.
REQ-025 pwr_up_req=0 in RAMP, SETTLE or ON SHALL move to DOWN with idx unchanged.
REQ-026 DOWN SHALL clear ena[idx], wait cfg_settle+1 cycles, then decrement idx; after rail 0 it SHALL go to OFF. Brown-out checks SHALL NOT apply in DOWN.
REQ-027 On entering FAULT, all ena bits SHALL clear in the same cycle, and fault=1 SHALL latch.
REQ-028 FAULT SHALL exit to OFF only when fault_clr=1 and pwr_up_req=0 in the same cycle; fault_clr with pwr_up_req=1 SHALL be ignored.
REQ-029 If a fault condition and pwr_up_req=0 occur in the same cycle, FAULT SHALL take priority.
REQ-030 pwr_up_req=1 in DOWN SHALL be ignored until OFF is reached.
REQ-031 All outputs SHALL be registered, with one cycle from state change to output.

Reset
REQ-032 reset=1 SHALL force state=OFF, ena=0, pwr_good=0, por=1, fault=0, fault_ch=0, fault_code=0, idx=0 and counter=0 on the next clk edge, including mid-sequence.

Structure
REQ-033 The state enum and fault_code enum SHALL live in a shared package pmu_seq_pkg.
REQ-034 The block SHALL contain one sub-module, pmu_seq_cnt, a TW-bit clearable up-counter with a terminal-compare output, used for both timeout and settle.

Verification (NCH=4, cfg_timeout=10, cfg_settle=3)
REQ-035 Nominal power-up: raise pwr_up_req, answer each rdy 2 cycles after its ena -> ena fills 0001, 0011, 0111, 1111 in order; pwr_good=1 and por=0 after the fourth SETTLE.
REQ-036 Timeout: hold rdy[2]=0 -> FAULT after 11 RAMP cycles on rail 2; fault_code=1, fault_ch=2, ena=0000 in the same cycle.
REQ-037 Brown-out in ON: pulse vlo[1] and vlo[3] together for 1 cycle -> FAULT with fault_code=2 and fault_ch=1; fault_clr with pwr_up_req=1 leaves fault=1, then with pwr_up_req=0 returns to OFF.
REQ-038 Power-down: drop pwr_up_req in ON -> ena clears 1111, 0111, 0011, 0001, 0000, with each step 4 cycles apart; vlo asserted during DOWN does not fault.
REQ-039 Reset mid-RAMP of rail 1 -> all outputs at reset values next cycle; a new pwr_up_req restarts from rail 0.
REQ-040 Corner cases: cfg_timeout=0 with rdy low -> immediate fault; NCH=1 build completes power-up and power-down.
